// File: rtl/fc_out_layer_pkg.sv
// Shared definitions for the fully-connected spiking output layer: FSM
// encodings, AER field positions (common with the pool stage) and the
// weight table that backs the synaptic ROM.
package fc_out_pkg;

  localparam int AER_W     = 12;
  localparam int AER_CH_HI = 11;
  localparam int AER_CH_LO = 10;
  localparam int AER_M_HI  = 9;
  localparam int AER_M_LO  = 5;
  localparam int AER_N_HI  = 4;
  localparam int AER_N_LO  = 0;

  localparam int ROM_AW = 16;
  localparam int ROM_DW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_TAIL = 2'd2,
    S_CLR  = 2'd3
  } state_e;

  // Build a pooled spike address from its channel / row / column fields.
  function automatic logic [AER_W-1:0] aer_pack(input logic [1:0] ch,
                                                input logic [4:0] m,
                                                input logic [4:0] n);
    logic [AER_W-1:0] a;
    a = '0;
    a[AER_CH_HI:AER_CH_LO] = ch;
    a[AER_M_HI:AER_M_LO]   = m;
    a[AER_N_HI:AER_N_LO]   = n;
    return a;
  endfunction

  // Synaptic weight table indexed by {aer, neuron}. Unlisted entries are 0.
  function automatic logic signed [ROM_DW-1:0] weight_f(input logic [ROM_AW-1:0] addr);
    logic [AER_W-1:0]         aer;
    logic [3:0]               j;
    logic signed [ROM_DW-1:0] w;
    aer = addr[15:4];
    j   = addr[3:0];
    w   = '0;
    case (aer)
      12'h0A4, 12'h0A5: if (j == 4'd3) w = 8'sd127;
      12'h0A6:          if (j == 4'd3) w = 8'sd2;
      12'h100:          if (j == 4'd0) w = 8'sd127;
      12'h102:          if (j == 4'd0) w = 8'sd2;
      12'h010:          if (j == 4'd7) w = 8'sd16;
      12'h200:          if (j == 4'd1) w = 8'sh80;
      12'h201:          if (j == 4'd1) w = 8'sd127;
      12'h300:          if (j == 4'd5 || j == 4'd6) w = 8'sd100;
      12'h301:          if (j == 4'd5) w = 8'sd100;
      12'h3C7: begin
        case (j)
          4'd0:    w = 8'sd60;
          4'd1:    w = -8'sd30;
          4'd2:    w = 8'sd90;
          4'd3:    w = 8'sd127;
          4'd4:    w = 8'sh80;
          4'd5:    w = 8'sd45;
          4'd6:    w = 8'sd75;
          4'd7:    w = -8'sd5;
          4'd8:    w = 8'sd110;
          4'd9:    w = 8'sd33;
          default: w = '0;
        endcase
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fc_out_layer_if.sv
// Spike bus between the pool stage, this layer and its consumer.
// Handshake: pool_spike_emit_i and out_spike_valid_o are single-cycle
// strobes with no ready; the receiving side must take every pulse in the
// cycle it is high, and the payload is only meaningful while it is high.
interface fc_out_layer_if #(
  parameter int ID_W = 4
);
  logic [11:0]     pool_spike_aer_i;
  logic            pool_spike_emit_i;
  logic            out_spike_valid_o;
  logic [ID_W-1:0] out_spike_id_o;

  modport master (
    output pool_spike_aer_i,
    output pool_spike_emit_i,
    input  out_spike_valid_o,
    input  out_spike_id_o
  );

  modport slave (
    input  pool_spike_aer_i,
    input  pool_spike_emit_i,
    output out_spike_valid_o,
    output out_spike_id_o
  );
endinterface

// File: rtl/fc_out_layer_weight_rom.sv
// Synchronous synaptic weight ROM: address in one cycle, weight out the next.
module fc_weight_rom
  import fc_out_pkg::*;
#(
  parameter int W_WIDTH = 8
) (
  input  logic                      work_clk,
  input  logic                      rst_n,
  input  logic [ROM_AW-1:0]         addr_i,
  output logic signed [W_WIDTH-1:0] data_o
);

  logic signed [W_WIDTH-1:0] data_d;
  logic signed [W_WIDTH-1:0] data_q;

  // Table lookup for the presented address.
  always_comb begin
    data_d = W_WIDTH'(weight_f(addr_i));
  end

  // Register the read data to give the one-cycle ROM latency.
  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/fc_out_layer.sv
// Fully-connected integrate-and-fire output layer. Pooled spikes are queued
// in a FIFO (the pool stage cannot be stalled), then each one is replayed
// against all N_OUT neurons: one ROM read per neuron, accumulate with
// saturation one cycle later, fire registered one cycle after that.
module fc_out_layer
  import fc_out_pkg::*;
#(
  parameter int N_OUT      = 10,
  parameter int ID_W       = 4,
  parameter int W_WIDTH    = 8,
  parameter int V_WIDTH    = 16,
  parameter int THRESH     = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic           work_clk,
  input  logic           rst_n,
  fc_out_layer_if.slave  spk,
  input  logic           clear_i,
  output logic           busy_o,
  output logic           fifo_overflow_o,
  output logic [15:0]    drop_cnt_o,
  output state_e         dbg_state_o
);

  localparam logic [ID_W-1:0]           J_LAST    = ID_W'(N_OUT - 1);
  localparam logic [FIFO_AW:0]          FIFO_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic signed [V_WIDTH-1:0] V_MAX     = {1'b0, {(V_WIDTH-1){1'b1}}};
  localparam logic signed [V_WIDTH-1:0] V_MIN     = {1'b1, {(V_WIDTH-1){1'b0}}};
  localparam logic signed [V_WIDTH-1:0] V_THRESH  = V_WIDTH'(THRESH);

  state_e                    state_q, state_d;
  logic [AER_W-1:0]          fifo_mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]          fifo_cnt_q, fifo_cnt_d;
  logic [AER_W-1:0]          cur_aer_q, cur_aer_d;
  logic [ID_W-1:0]           j_q, j_d;
  logic                      acc_vld_q, acc_vld_d;
  logic [ID_W-1:0]           acc_idx_q, acc_idx_d;
  logic                      clr_pend_q, clr_pend_d;
  logic signed [V_WIDTH-1:0] v_q [N_OUT];
  logic signed [V_WIDTH-1:0] v_d [N_OUT];
  logic                      out_vld_q, out_vld_d;
  logic [ID_W-1:0]           out_id_q, out_id_d;
  logic                      ovf_q, ovf_d;
  logic [15:0]               drop_cnt_q, drop_cnt_d;

  logic                      fifo_empty, fifo_full;
  logic                      push, drop, pop, clr_req;
  logic [ROM_AW-1:0]         rom_addr;
  logic signed [W_WIDTH-1:0] rom_data;
  logic signed [V_WIDTH-1:0] v_cur;
  logic signed [V_WIDTH:0]   acc_sum;
  logic signed [V_WIDTH-1:0] acc_sat;
  logic                      acc_fire;

  fc_weight_rom #(.W_WIDTH(W_WIDTH)) u_rom (
    .work_clk (work_clk),
    .rst_n    (rst_n),
    .addr_i   (rom_addr),
    .data_o   (rom_data)
  );

  // FIFO status and the saturating accumulate for the neuron whose weight is on the ROM output.
  always_comb begin
    fifo_empty = (fifo_cnt_q == '0);
    fifo_full  = (fifo_cnt_q == FIFO_FULL);
    push       = spk.pool_spike_emit_i & ~fifo_full;
    drop       = spk.pool_spike_emit_i & fifo_full;
    clr_req    = clr_pend_q | clear_i;
    pop        = (state_q == S_IDLE) & ~clr_req & ~fifo_empty;
    rom_addr   = {cur_aer_q, j_q};
    v_cur      = v_q[acc_idx_q];
    acc_sum    = {v_cur[V_WIDTH-1], v_cur}
               + {{(V_WIDTH+1-W_WIDTH){rom_data[W_WIDTH-1]}}, rom_data};
    if (acc_sum[V_WIDTH] != acc_sum[V_WIDTH-1]) acc_sat = acc_sum[V_WIDTH] ? V_MIN : V_MAX;
    else                                        acc_sat = acc_sum[V_WIDTH-1:0];
    acc_fire   = (acc_sat >= V_THRESH);
  end

  // Next-state for the sequencer, FIFO pointers, membranes, fire output and drop bookkeeping.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    cur_aer_d  = cur_aer_q;
    j_d        = j_q;
    acc_vld_d  = 1'b0;
    acc_idx_d  = acc_idx_q;
    clr_pend_d = clr_pend_q | clear_i;
    v_d        = v_q;
    out_vld_d  = 1'b0;
    out_id_d   = '0;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLR;
        end else if (!fifo_empty) begin
          cur_aer_d = fifo_mem_q[rd_ptr_q];
          j_d       = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        acc_vld_d = 1'b1;
        acc_idx_d = j_q;
        j_d       = j_q + 1'b1;
        if (j_q == J_LAST) state_d = S_TAIL;
      end
      S_TAIL: state_d = S_IDLE;
      S_CLR: begin
        state_d    = S_IDLE;
        clr_pend_d = clear_i;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    if (acc_vld_q) begin
      v_d[acc_idx_q] = acc_fire ? '0 : acc_sat;
      out_vld_d      = acc_fire;
      out_id_d       = acc_fire ? acc_idx_q : '0;
    end

    if (state_q == S_CLR) begin
      for (int i = 0; i < N_OUT; i++) v_d[i] = '0;
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
  end

  // Control and datapath registers; reset aborts any spike in flight.
  always_ff @(posedge work_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      cur_aer_q  <= '0;
      j_q        <= '0;
      acc_vld_q  <= 1'b0;
      acc_idx_q  <= '0;
      clr_pend_q <= 1'b0;
      for (int i = 0; i < N_OUT; i++) v_q[i] <= '0;
      out_vld_q  <= 1'b0;
      out_id_q   <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      cur_aer_q  <= cur_aer_d;
      j_q        <= j_d;
      acc_vld_q  <= acc_vld_d;
      acc_idx_q  <= acc_idx_d;
      clr_pend_q <= clr_pend_d;
      v_q        <= v_d;
      out_vld_q  <= out_vld_d;
      out_id_q   <= out_id_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge work_clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= spk.pool_spike_aer_i;
  end

  assign spk.out_spike_valid_o = out_vld_q;
  assign spk.out_spike_id_o    = out_id_q;
  assign busy_o                = (state_q != S_IDLE) | ~fifo_empty;
  assign fifo_overflow_o       = ovf_q;
  assign drop_cnt_o            = drop_cnt_q;
  assign dbg_state_o           = state_q;

endmodule
